// File: rtl/test_ctrl_pkg.sv
// Shared state encoding, tag constants and the default-width stream entry
// layout for test_ctrl_monitor and its consumers.
package test_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE,
        TIMEOUT
    } tc_state_e;

    localparam logic [3:0] TAG_SIG = 4'd0;

    localparam int unsigned TC_DATA_W = 32;
    localparam int unsigned TC_CNT_W  = 40;

    // Entry layout at the default DATA_W/CNT_W; the FIFO stores the same
    // fields packed in this order, dropping stamp when timestamps are off.
    typedef struct packed {
        logic [3:0]           tag;
        logic [TC_DATA_W-1:0] data;
        logic [TC_CNT_W-1:0]  stamp;
    } tc_entry_t;

endpackage

// File: rtl/tc_fifo.sv
// Generic first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
// Full/empty use an extra pointer MSB; read data is zero while empty.
module tc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A push into a full FIFO is only taken when a pop frees the slot.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/test_ctrl_monitor.sv
// Test control / log collector: merges signature writes and channel bytes into
// one tagged stream, tracks halt/exit code, runs a cycle watchdog.
// Optional TEST_CTRL_TIMESTAMP_EN stores the cycle counter with each entry.
module test_ctrl_monitor
    import test_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       NUM_CH     = 2,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0] SIG_ADDR   = ADDR_W'(32'h8E000000),
    parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(32'h8F000000),
    parameter int unsigned       CNT_W      = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_wr_i,
    input  logic [ADDR_W-1:0]   bus_addr_i,
    input  logic [DATA_W-1:0]   bus_wdata_i,
    input  logic [NUM_CH-1:0]   ch_valid_i,
    input  logic [8*NUM_CH-1:0] ch_data_i,
    output logic [NUM_CH-1:0]   ch_ready_o,
    input  logic [CNT_W-1:0]    max_cycles_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [3:0]          out_tag_o,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [CNT_W-1:0]    out_stamp_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   exit_code_o,
    output logic                timeout_o,
    output logic                overflow_o
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef TEST_CTRL_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = 4 + DATA_W + CNT_W;
`else
    localparam int unsigned ENTRY_W = 4 + DATA_W;
`endif

    tc_state_e           r_state;
    tc_state_e           w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_exit;
    logic                r_overflow;
    logic [CH_W-1:0]     r_last;

    logic                w_active;
    logic                w_sig_wr;
    logic                w_halt_wr;
    logic                w_wd_hit;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_found;
    logic [CH_W-1:0]     w_gnt_idx;
    int unsigned         w_cand;
    logic                w_ch_ok;
    logic [NUM_CH-1:0]   w_ch_ready;
    logic [3:0]          w_push_tag;
    logic [DATA_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]  w_wdata;
    logic [ENTRY_W-1:0]  w_rdata;

    assign w_active  = (r_state == RUN) || (r_state == DRAIN);
    assign w_sig_wr  = w_active && bus_wr_i && (bus_addr_i == SIG_ADDR);
    assign w_halt_wr = (r_state == RUN) && bus_wr_i && (bus_addr_i == HALT_ADDR);
    assign w_wd_hit  = (max_cycles_i != '0) && (r_cnt == max_cycles_i);
    assign w_pop     = !w_empty && out_ready_i;

    // Round-robin search starts one past the last accepted channel.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = r_last;
        w_cand    = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            w_cand = 32'(r_last) + i;
            if (w_cand >= NUM_CH) w_cand = w_cand - NUM_CH;
            if (!w_found && ch_valid_i[CH_W'(w_cand)]) begin
                w_found   = 1'b1;
                w_gnt_idx = CH_W'(w_cand);
            end
        end
    end

    assign w_ch_ok = w_active && !w_sig_wr && w_found && (!w_full || w_pop);
    assign w_push  = w_ch_ok || (w_sig_wr && (!w_full || w_pop));

    always_comb begin
        w_ch_ready = '0;
        if (w_ch_ok) w_ch_ready[w_gnt_idx] = 1'b1;
    end
    assign ch_ready_o = w_ch_ready;

    always_comb begin
        w_push_tag  = TAG_SIG;
        w_push_data = bus_wdata_i;
        if (!w_sig_wr) begin
            w_push_tag  = 4'(w_gnt_idx) + 4'd1;
            w_push_data = DATA_W'(ch_data_i[8*w_gnt_idx +: 8]);
        end
    end

`ifdef TEST_CTRL_TIMESTAMP_EN
    assign w_wdata = {w_push_tag, w_push_data, r_cnt};
    assign {out_tag_o, out_data_o, out_stamp_o} = w_rdata;
`else
    assign w_wdata = {w_push_tag, w_push_data};
    assign {out_tag_o, out_data_o} = w_rdata;
    assign out_stamp_o = '0;
`endif

    tc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Watchdog wins over a coincident halt; DRAIN waits for a truly idle FIFO.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_wd_hit)       w_state_nxt = TIMEOUT;
                else if (w_halt_wr) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_wd_hit)                w_state_nxt = TIMEOUT;
                else if (w_empty && !w_push) w_state_nxt = DONE;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_exit     <= '0;
            r_overflow <= 1'b0;
            r_last     <= CH_W'(NUM_CH - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_active && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
            if (w_halt_wr && !w_wd_hit) r_exit <= bus_wdata_i;
            if (w_sig_wr && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_ch_ok) r_last <= w_gnt_idx;
        end
    end

    assign out_valid_o = !w_empty;
    assign done_o      = (r_state == DONE);
    assign timeout_o   = (r_state == TIMEOUT);
    assign exit_code_o = r_exit;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_test_ctrl_monitor.sv
// Scoreboard bench for test_ctrl_monitor: expected entries queued at drive
// time, compared in order as the output stream pops.
`timescale 1ns/1ps
module tb_test_ctrl_monitor;
    import test_ctrl_pkg::*;

    localparam int unsigned NUM_CH = 2;
    localparam logic [31:0] SIG    = 32'h8E000000;
    localparam logic [31:0] HALT   = 32'h8F000000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bus_wr_i;
    logic [31:0]       bus_addr_i;
    logic [31:0]       bus_wdata_i;
    logic [NUM_CH-1:0] ch_valid_i;
    logic [15:0]       ch_data_i;
    logic [NUM_CH-1:0] ch_ready_o;
    logic [39:0]       max_cycles_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [3:0]        out_tag_o;
    logic [31:0]       out_data_o;
    logic [39:0]       out_stamp_o;
    logic              done_o;
    logic [31:0]       exit_code_o;
    logic              timeout_o;
    logic              overflow_o;

    tc_entry_t   sb[$];
    int unsigned n_checks  = 0;
    int unsigned n_fail    = 0;
    int unsigned pop_count = 0;
    bit          rr_chk    = 1'b0;
    int unsigned rr_last   = NUM_CH - 1;
    bit          stamp_seen = 1'b0;
    logic [39:0] last_stamp = '0;

    test_ctrl_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_wr_i     (bus_wr_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wdata_i  (bus_wdata_i),
        .ch_valid_i   (ch_valid_i),
        .ch_data_i    (ch_data_i),
        .ch_ready_o   (ch_ready_o),
        .max_cycles_i (max_cycles_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_tag_o    (out_tag_o),
        .out_data_o   (out_data_o),
        .out_stamp_o  (out_stamp_o),
        .done_o       (done_o),
        .exit_code_o  (exit_code_o),
        .timeout_o    (timeout_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output-side monitor plus channel-acceptance capture, away from posedge.
    always @(negedge clk) begin
        tc_entry_t         e;
        logic [NUM_CH-1:0] exp_rdy;
        int unsigned       idx;
        int unsigned       c;
        if (rst_n) begin
            if (out_valid_o && out_ready_i) begin
                pop_count++;
                check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_val("out_tag", 64'(out_tag_o), 64'(e.tag));
                    check_val("out_data", 64'(out_data_o), 64'(e.data));
                end
`ifdef TEST_CTRL_TIMESTAMP_EN
                if (stamp_seen) check_val("stamp_mono", 64'(out_stamp_o > last_stamp), 64'd1);
                last_stamp = out_stamp_o;
                stamp_seen = 1'b1;
`endif
            end
            if (rr_chk) begin
                exp_rdy = '0;
                idx     = rr_last;
                for (int unsigned i = 1; i <= NUM_CH; i++) begin
                    c = (rr_last + i) % NUM_CH;
                    if (exp_rdy == '0 && ch_valid_i[c]) begin
                        exp_rdy[c] = 1'b1;
                        idx = c;
                    end
                end
                check_val("rr_grant", 64'(ch_ready_o), 64'(exp_rdy));
                if (exp_rdy != '0) rr_last = idx;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid_i[k] && ch_ready_o[k])
                    sb.push_back('{tag: 4'(k + 1), data: 32'(ch_data_i[8*k +: 8]), stamp: '0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [39:0] maxc);
        rst_n        = 1'b0;
        bus_wr_i     = 1'b0;
        bus_addr_i   = '0;
        bus_wdata_i  = '0;
        ch_valid_i   = '0;
        ch_data_i    = '0;
        max_cycles_i = maxc;
        sb.delete();
        stamp_seen   = 1'b0;
        rr_last      = NUM_CH - 1;
        pop_count    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input bit exp_push);
        bus_wr_i    = 1'b1;
        bus_addr_i  = addr;
        bus_wdata_i = data;
        if (exp_push) sb.push_back('{tag: TAG_SIG, data: data, stamp: '0});
        tick();
        bus_wr_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while ((sb.size() != 0 || out_valid_o) && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, 64'(sb.size()), 64'd0);
        check_val({tag, "_valid"}, 64'(out_valid_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        out_ready_i = 1'b1;
        rst_n       = 1'b0;
        bus_wr_i    = 1'b0;
        bus_addr_i  = '0;
        bus_wdata_i = '0;
        ch_valid_i  = '0;
        ch_data_i   = '0;
        max_cycles_i = '0;
        #3;
        check_val("rst_valid", 64'(out_valid_o), 64'd0);
        check_val("rst_done", 64'(done_o), 64'd0);
        check_val("rst_timeout", 64'(timeout_o), 64'd0);
        check_val("rst_overflow", 64'(overflow_o), 64'd0);
        check_val("rst_exit", 64'(exit_code_o), 64'd0);
        check_val("rst_data", 64'(out_data_o), 64'd0);

        // Signature stream, halt, done one cycle after the FIFO empties.
        do_reset('0);
        bus_write(SIG, 32'hDEADBEEF, 1'b1);
        bus_write(SIG, 32'h12345678, 1'b1);
        bus_write(HALT, 32'h1, 1'b0);
        check_val("halt_exit", 64'(exit_code_o), 64'd1);
        check_val("halt_empty", 64'(out_valid_o), 64'd0);
        check_val("halt_not_done", 64'(done_o), 64'd0);
        tick();
        check_val("done", 64'(done_o), 64'd1);
        check_val("t1_sb", 64'(sb.size()), 64'd0);
        ch_valid_i = 2'b11;
        #1;
        check_val("done_ch_ready", 64'(ch_ready_o), 64'd0);
        ch_valid_i = '0;
        bus_write(SIG, 32'hAAAA5555, 1'b0);
        check_val("done_sig_ignored", 64'(out_valid_o), 64'd0);
        check_val("t1_overflow", 64'(overflow_o), 64'd0);

        // Both channels valid continuously: grants alternate from channel 0.
        do_reset('0);
        rr_chk     = 1'b1;
        ch_valid_i = 2'b11;
        for (int unsigned cyc = 0; cyc < 8; cyc++) begin
            ch_data_i = {8'(8'h80 + cyc), 8'(cyc)};
            tick();
        end
        rr_chk     = 1'b0;
        ch_valid_i = '0;
        wait_drain("t2_drain");

        // Overflow: 16 stored, 17th dropped, then exactly 16 pop in order.
        do_reset('0);
        out_ready_i = 1'b0;
        for (int unsigned i = 0; i < 16; i++) bus_write(SIG, 32'h100 + i, 1'b1);
        check_val("full_no_ovf", 64'(overflow_o), 64'd0);
        bus_write(SIG, 32'h1FF, 1'b0);
        check_val("ovf_set", 64'(overflow_o), 64'd1);
        pop_count   = 0;
        out_ready_i = 1'b1;
        wait_drain("t3_drain");
        check_val("ovf_pops", 64'(pop_count), 64'd16);
        check_val("ovf_sticky", 64'(overflow_o), 64'd1);

        // Signature beats a concurrent channel byte; channel follows next cycle.
        do_reset('0);
        ch_data_i   = 16'h0055;
        ch_valid_i  = 2'b01;
        bus_wr_i    = 1'b1;
        bus_addr_i  = SIG;
        bus_wdata_i = 32'hCAFEF00D;
        sb.push_back('{tag: TAG_SIG, data: 32'hCAFEF00D, stamp: '0});
        #3;
        check_val("sig_prio_rdy", 64'(ch_ready_o), 64'd0);
        tick();
        bus_wr_i = 1'b0;
        #3;
        check_val("ch0_after_sig", 64'(ch_ready_o), 64'd1);
        tick();
        ch_valid_i = '0;
        wait_drain("t4_drain");

        // Watchdog at 100: rises after the 101st edge, then channels blocked.
        do_reset(40'd100);
        for (int unsigned i = 1; i <= 101; i++) begin
            tick();
            if (i == 100) check_val("wd_before", 64'(timeout_o), 64'd0);
            if (i == 101) check_val("wd_fire", 64'(timeout_o), 64'd1);
        end
        ch_valid_i = 2'b01;
        #1;
        check_val("wd_ch_ready", 64'(ch_ready_o), 64'd0);
        check_val("wd_not_done", 64'(done_o), 64'd0);
        ch_valid_i = '0;
        repeat (5) tick();
        check_val("wd_sticky", 64'(timeout_o), 64'd1);

        do_reset('0);
        repeat (300) tick();
        check_val("wd_disabled", 64'(timeout_o), 64'd0);

        // Reset while draining with 5 queued entries.
        do_reset('0);
        out_ready_i = 1'b0;
        for (int unsigned i = 0; i < 5; i++) bus_write(SIG, 32'h500 + i, 1'b1);
        bus_write(HALT, 32'h77, 1'b0);
        bus_write(HALT, 32'h99, 1'b0);
        check_val("drain_exit_first", 64'(exit_code_o), 64'h77);
        check_val("drain_not_done", 64'(done_o), 64'd0);
        check_val("drain_valid", 64'(out_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(out_valid_o), 64'd0);
        check_val("mid_rst_exit", 64'(exit_code_o), 64'd0);
        check_val("mid_rst_data", 64'(out_data_o), 64'd0);
        check_val("mid_rst_tag", 64'(out_tag_o), 64'd0);
        do_reset('0);
        out_ready_i = 1'b1;
        bus_write(SIG, 32'h0000BEEF, 1'b1);
        bus_write(HALT, 32'h2, 1'b0);
        check_val("post_rst_exit", 64'(exit_code_o), 64'd2);
        tick();
        check_val("post_rst_done", 64'(done_o), 64'd1);
        check_val("final_sb", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
